alu_op_sequencer: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 36 +++
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_ctrl_decode.sv | 38 +++
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: command opcodes, ALU
// operation codes, sequencer state encoding and multiply loop length.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_ADD     = 3'd2,
        OP_SUB     = 3'd3,
        OP_SLT     = 3'd4,
        OP_NOR     = 3'd5,
        OP_MUL     = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_RESP = 2'd3
    } state_e;

    localparam int MUL_STEPS = 32;
    localparam int CNT_W     = 5;

    // Ops that map onto one pass through the ALU.
    function automatic logic is_single_cycle(op_e op);
        return (op <= OP_NOR);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response channels between the issue logic (master) and the
// ALU sequencer (slave).
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational translation of a command opcode into the ripple ALU's
// ainv/binv/operation control lines; non-ALU opcodes decode to all zeros.
module alu_ctrl_decode
    import alu_seq_pkg::*;
(
    input  op_e        op,
    output logic       ainv,
    output logic       binv,
    output logic [1:0] operation
);

    always_comb begin
        ainv      = 1'b0;
        binv      = 1'b0;
        operation = ALU_AND;
        case (op)
            OP_AND: operation = ALU_AND;
            OP_OR:  operation = ALU_OR;
            OP_ADD: operation = ALU_ADD;
            OP_SUB: begin
                binv      = 1'b1;
                operation = ALU_ADD;
            end
            OP_SLT: begin
                binv      = 1'b1;
                operation = ALU_SLT;
            end
            // De Morgan: ~a & ~b
            OP_NOR: begin
                ainv      = 1'b1;
                binv      = 1'b1;
                operation = ALU_AND;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Command front-end for the shared 32-bit ripple ALU: single-cycle logic and
// arithmetic ops, plus a 32-step shift-add multiply reusing the ALU adder.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic              busy,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_ainv,
    output logic              alu_binv,
    output logic [1:0]        alu_operation,
    input  logic [WIDTH-1:0]  alu_res
);

    if (WIDTH != 32) begin : g_width_check
        $error("alu_op_sequencer: WIDTH must be 32 to match the ALU");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_STEPS - 1);

    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, rsp_data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rsp_zero_q, rsp_err_q;

    op_e              cmd_op;
    logic             cmd_single, cmd_mul, cmd_legal, mul_last;
    logic [WIDTH-1:0] acc_next;
    logic             dec_ainv, dec_binv;
    logic [1:0]       dec_operation;

    assign cmd_op     = op_e'(bus.cmd_op);
    assign cmd_single = is_single_cycle(cmd_op);
    assign cmd_mul    = MUL_EN && (cmd_op == OP_MUL);
    assign cmd_legal  = cmd_single || cmd_mul;
    assign mul_last   = (cnt_q == CNT_LAST);
    // During MUL opa_q holds the shifted multiplicand and opb_q the multiplier.
    assign acc_next   = opb_q[0] ? alu_res : acc_q;

    alu_ctrl_decode u_decode (
        .op        (op_q),
        .ainv      (dec_ainv),
        .binv      (dec_binv),
        .operation (dec_operation)
    );

    // Ready is gated by reset so every output reads zero while rst_n is low.
    assign bus.cmd_ready = rst_n && (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_a         = '0;
        alu_b         = '0;
        alu_ainv      = 1'b0;
        alu_binv      = 1'b0;
        alu_operation = ALU_AND;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (cmd_single)   state_d = S_EXEC;
                    else if (cmd_mul) state_d = S_MUL;
                    else              state_d = S_RESP;
                end
            end
            S_EXEC: begin
                alu_a         = opa_q;
                alu_b         = opb_q;
                alu_ainv      = dec_ainv;
                alu_binv      = dec_binv;
                alu_operation = dec_operation;
                state_d       = S_RESP;
            end
            S_MUL: begin
                alu_a         = acc_q;
                alu_b         = opa_q;
                alu_operation = ALU_ADD;
                if (mul_last) state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_AND;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q      <= cmd_op;
                        opa_q     <= bus.cmd_a;
                        opb_q     <= bus.cmd_b;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        rsp_err_q <= !cmd_legal;
                        if (!cmd_legal) begin
                            rsp_data_q <= '0;
                            rsp_zero_q <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_data_q <= alu_res;
                    rsp_zero_q <= (alu_res == '0);
                end
                S_MUL: begin
                    acc_q <= acc_next;
                    opa_q <= opa_q << 1;
                    opb_q <= opb_q >> 1;
                    if (mul_last) begin
                        rsp_data_q <= acc_next;
                        rsp_zero_q <= (acc_next == '0);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: a behavioural ALU drives alu_res, and a
// scoreboard of expected responses is checked against the DUT every cycle.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(32)) bus ();
    alu_op_sequencer_if #(.WIDTH(32)) bus_nm ();

    logic        busy, ainv, binv;
    logic [1:0]  aop;
    logic [31:0] alu_a, alu_b, alu_res;
    logic        busy_nm, ainv_nm, binv_nm;
    logic [1:0]  aop_nm;
    logic [31:0] alu_a_nm, alu_b_nm, alu_res_nm;

    // Reference ripple ALU: invert, then AND / OR / ADD(cin=binv) / SLT.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic ai, input logic bi, input logic [1:0] o);
        logic [31:0] aa, bb, s;
        aa = ai ? ~a : a;
        bb = bi ? ~b : b;
        s  = aa + bb + {31'd0, bi};
        case (o)
            2'b00:   return aa & bb;
            2'b01:   return aa | bb;
            2'b10:   return s;
            default: return {31'd0, s[31]};
        endcase
    endfunction

    assign alu_res    = alu_model(alu_a, alu_b, ainv, binv, aop);
    assign alu_res_nm = alu_model(alu_a_nm, alu_b_nm, ainv_nm, binv_nm, aop_nm);

    alu_op_sequencer #(.WIDTH(32), .MUL_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ainv(ainv), .alu_binv(binv),
        .alu_operation(aop), .alu_res(alu_res)
    );

    alu_op_sequencer #(.WIDTH(32), .MUL_EN(1'b0)) u_dut_nm (
        .clk(clk), .rst_n(rst_n), .bus(bus_nm), .busy(busy_nm),
        .alu_a(alu_a_nm), .alu_b(alu_b_nm), .alu_ainv(ainv_nm), .alu_binv(binv_nm),
        .alu_operation(aop_nm), .alu_res(alu_res_nm)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          t_acc;
    } txn_t;

    txn_t q[$];

    // Specification-level result: plain arithmetic on the operands.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input bit mul_en, output logic [31:0] d, output logic e,
                                  output int lat);
        logic [31:0] diff;
        logic [63:0] prod;
        diff = a - b;
        prod = {32'd0, a} * {32'd0, b};
        e = 1'b0;
        lat = 2;
        case (op)
            3'd0: d = a & b;
            3'd1: d = a | b;
            3'd2: d = a + b;
            3'd3: d = diff;
            3'd4: d = {31'd0, diff[31]};
            3'd5: d = ~(a | b);
            3'd6: begin
                d = mul_en ? prod[31:0] : 32'd0;
                e = !mul_en;
                lat = mul_en ? 33 : 1;
            end
            default: begin
                d = 32'd0;
                e = 1'b1;
                lat = 1;
            end
        endcase
    endfunction

    logic [3:0]  ctrl_tbl [0:5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    bit          front_seen = 0;
    int          ph, k, last_lat;
    logic [31:0] msk, last_data;
    logic [63:0] part;
    logic        last_err, last_zero;

    // Compare process: phase of the oldest command decides every expected output.
    always @(negedge clk) begin
        if (!rst_n) begin
            front_seen = 0;
            chk("reset_outputs",
                64'({busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_zero, bus.rsp_err, ainv, binv,
                     |aop, |bus.rsp_data, |alu_a, |alu_b}), 64'd0);
        end else begin
            ph = 0;
            if (q.size() > 0 && cyc > q[0].t_acc)
                ph = (cyc < q[0].t_acc + q[0].lat) ? 1 : 2;
            chk("busy", 64'(busy), 64'(ph != 0));
            chk("cmd_ready", 64'(bus.cmd_ready), 64'(ph == 0));
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(ph == 2));
            if (ph == 1 && q[0].op == 3'd6) begin
                k = cyc - q[0].t_acc - 1;
                msk = (k == 0) ? 32'd0 : (32'hFFFF_FFFF >> (32 - k));
                part = {32'd0, q[0].a} * {32'd0, q[0].b & msk};
                chk("mul_ctl", 64'({ainv, binv, aop}), 64'(4'b0010));
                chk("mul_operands", {alu_a, alu_b}, {part[31:0], q[0].a << k});
            end else if (ph == 1) begin
                chk("exec_ctl", 64'({ainv, binv, aop}), 64'(ctrl_tbl[q[0].op]));
                chk("exec_operands", {alu_a, alu_b}, {q[0].a, q[0].b});
            end else begin
                chk("alu_idle", 64'({ainv, binv, aop, |alu_a, |alu_b}), 64'd0);
            end
            if (ph == 2) begin
                if (!front_seen) begin
                    last_lat = cyc - q[0].t_acc;
                    chk("latency", 64'(last_lat), 64'(q[0].lat));
                    front_seen = 1;
                end
                chk("rsp_data", 64'(bus.rsp_data), 64'(q[0].data));
                chk("rsp_zero", 64'(bus.rsp_zero), 64'(q[0].data == 32'd0));
                chk("rsp_err", 64'(bus.rsp_err), 64'(q[0].err));
                last_data = bus.rsp_data;
                last_zero = bus.rsp_zero;
                last_err  = bus.rsp_err;
                if (bus.rsp_ready) begin
                    void'(q.pop_front());
                    front_seen = 0;
                end
            end
        end
    end

    // Called and returns at posedge+1; the command is accepted at the next edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        txn_t t;
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.cmd_ready) begin
            chk("cmd_ready_timeout", 64'd0, 64'd1);
        end else begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op = op;
            bus.cmd_a = a;
            bus.cmd_b = b;
            t.op = op;
            t.a = a;
            t.b = b;
            model(op, a, b, 1'b1, t.data, t.err, t.lat);
            t.t_acc = cyc;
            q.push_back(t);
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (q.size() != 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        if (q.size() != 0) begin
            chk("response_timeout", 64'd0, 64'd1);
            q.delete();
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e,
                       input int exp_lat);
        send(op, a, b);
        wait_done();
        chk(name, 64'(last_data), 64'(exp_d));
        chk({name, "_err"}, 64'(last_err), 64'(exp_e));
        chk({name, "_zero"}, 64'(last_zero), 64'(exp_d == 32'd0));
        chk({name, "_lat"}, 64'(last_lat), 64'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_a = '0; bus.cmd_b = '0;
        bus.rsp_ready = 1'b1;
        bus_nm.cmd_valid = 1'b0; bus_nm.cmd_op = 3'd0; bus_nm.cmd_a = '0; bus_nm.cmd_b = '0;
        bus_nm.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 64'(bus.cmd_ready), 64'd1);
        chk("idle_after_reset", 64'({busy, bus.rsp_valid}), 64'd0);

        run("add", 3'd2, 32'd4500, 32'd32678, 32'd37178, 1'b0, 2);
        run("sub", 3'd3, 32'd4500, 32'd32678, 32'hFFFF_91EE, 1'b0, 2);
        run("slt_lt", 3'd4, 32'd4500, 32'd32678, 32'h0000_0001, 1'b0, 2);
        run("slt_ge", 3'd4, 32'd5, 32'd3, 32'h0000_0000, 1'b0, 2);
        run("nor", 3'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 2);
        run("and", 3'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 2);
        run("or", 3'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 2);
        run("mul", 3'd6, 32'd4500, 32'd32678, 32'h08C3_D1F8, 1'b0, 33);
        run("mul_wrap", 3'd6, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 33);
        run("illegal", 3'd7, 32'd9, 32'd9, 32'h0000_0000, 1'b1, 1);

        // Backpressure: response held, stray commands must be ignored.
        bus.rsp_ready = 1'b0;
        send(3'd2, 32'd100, 32'd23);
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_op = 3'd3; bus.cmd_a = 32'd1; bus.cmd_b = 32'd2;
            @(posedge clk); #1;
            chk("bp_data_hold", 64'(bus.rsp_data), 64'd123);
            chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", 64'(bus.cmd_ready), 64'd1);
        chk("bp_result", 64'(last_data), 64'd123);
        run("after_bp", 3'd2, 32'd7, 32'd8, 32'd15, 1'b0, 2);

        // Reset asserted at MUL cycle 10.
        send(3'd6, 32'd4500, 32'd32678);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        chk("async_reset_outputs",
            64'({busy, bus.cmd_ready, bus.rsp_valid, bus.rsp_zero, bus.rsp_err, ainv, binv,
                 |aop, |bus.rsp_data, |alu_a, |alu_b}), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run("add_after_reset", 3'd2, 32'd1, 32'd1, 32'd2, 1'b0, 2);

        // MUL disabled: op 6 and op 7 are both illegal with T+1 latency.
        for (int i = 6; i < 8; i++) begin
            bus_nm.cmd_valid = 1'b1; bus_nm.cmd_op = 3'(i);
            bus_nm.cmd_a = 32'd5; bus_nm.cmd_b = 32'd7;
            @(posedge clk); #1;
            bus_nm.cmd_valid = 1'b0;
            chk("nm_rsp_valid", 64'(bus_nm.rsp_valid), 64'd1);
            chk("nm_rsp_err", 64'(bus_nm.rsp_err), 64'd1);
            chk("nm_rsp_data", 64'(bus_nm.rsp_data), 64'd0);
            chk("nm_rsp_zero", 64'(bus_nm.rsp_zero), 64'd1);
            @(posedge clk); #1;
            chk("nm_ready_again", 64'({bus_nm.cmd_ready, bus_nm.rsp_valid}), 64'b10);
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
